lfsr_multistep: RTL
===================

// Module: lfsr_multistep
// PURPOSE
//  Parametrised Fibonacci LFSR generator: width, tap mask and steps-per-clock are set by parameter.
//  Seed loading, an IDLE/RUN state machine, valid/ready output handshake and a produced-word counter.
//  Feeds the PRNG combiner stage; one instance per LFSR lane (L, M, ...).
// PARAMETERS
//  W            13        state width in bits, 2..64
//  TAPS         13'h100D  feedback mask; bit k set => s[k] in XOR feedback (bit W-1 must be set)
//  STEPS        2         LFSR shifts applied per accepted word, 1..W
//  SEED_DEFAULT 13'h0001  reset state and lockup-recovery state; must be non-zero
//  CNT_W        16        width of produced-word counter
// PORTS
//  i_clk       in   1      clock, rising edge
//  i_rst       in   1      reset, asynchronous, active-high
//  i_load      in   1      load i_seed into state (1-cycle strobe)
//  i_seed      in   W      seed value sampled when i_load=1
//  i_clear     in   1      return to IDLE, counter cleared, state kept
//  i_ready     in   1      consumer accepts o_lfsr this cycle
//  o_lfsr      out  W      current state word
//  o_valid     out  1      o_lfsr is valid
//  o_lockup    out  1      1-cycle pulse: all-zero state replaced (macro only)
//  o_word_cnt  out  CNT_W  words accepted since load/clear
// BEHAVIOUR
//  Step: fb = ^(s & TAPS); s_next = {fb, s[W-1:1]}; STEPS steps chained combinationally per update.
//  Reset (async): state=SEED_DEFAULT, FSM=IDLE, o_valid=0, o_lockup=0, o_word_cnt=0.
//  FSM IDLE: o_valid=0, state held; i_load -> state<=i_seed, cnt<=0, go RUN (o_valid=1 next cycle).
//  FSM RUN: o_valid=1; o_valid&i_ready -> state<=STEPS-step(state), cnt<=cnt+1 (wraps at 2^CNT_W).
//  RUN without i_ready: state, o_lfsr, cnt held (stall); o_lfsr must not change while o_valid&!i_ready.
//  Priority per cycle: i_clear > i_load > accept. i_clear in any state -> IDLE, cnt<=0, o_valid=0 next cycle.
//  i_load in RUN: reload i_seed, cnt<=0, stay RUN; simultaneous i_ready ignored (no advance, no count).
//  Latency: load at edge N -> o_lfsr=i_seed, o_valid=1 after edge N; accept at edge N -> new word after N.
//  Reset mid-RUN: immediate return to reset values regardless of clock.
//  o_lfsr = state register directly (no extra pipeline stage).
// CONFIGURATION
//  Macro LFSR_LOCKUP_RECOVER_EN:
//   defined: i_load with i_seed==0 loads SEED_DEFAULT instead and pulses o_lockup for 1 cycle;
//            any state update that would yield all-zero also substitutes SEED_DEFAULT + pulse.
//   undefined: zero seed loaded as-is, LFSR stays 0 forever; o_lockup tied 0.
// STRUCTURE
//  Shared package lfsr_pkg: FSM enum (LFSR_IDLE, LFSR_RUN), function lfsr_step(state, taps).
//  Sub-module lfsr_step_net #(W,TAPS,STEPS): pure combinational STEPS-deep unrolled step chain.
//  Top: FSM, state register, counter, lockup logic.
// TESTING (W=13, TAPS=13'h100D, SEED_DEFAULT=1 unless stated)
//  Reset then idle 5 cycles -> o_valid=0, o_lfsr=13'h0001, o_word_cnt=0.
//  STEPS=2: load 13'h0001, i_ready=1 -> words 13'h0001, 13'h1800, ...; cnt increments 1 per cycle.
//  STEPS=1: load 13'h0001, i_ready=1 -> 13'h0001, 13'h1000, 13'h1800, 13'h1C00; result matches STEPS=2 every other word.
//  Stall: i_ready=0 for 4 cycles in RUN -> o_lfsr and cnt frozen; resume continues sequence unbroken.
//  i_load and i_clear same cycle -> IDLE, o_valid=0, cnt=0; i_load+i_ready -> seed shown, cnt=0.
//  Load seed 0: with LFSR_LOCKUP_RECOVER_EN -> o_lfsr=13'h0001, o_lockup one-cycle pulse; without -> o_lfsr stays 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the multistep Fibonacci LFSR lanes: FSM encoding and
// a single-step helper that works on a 64-bit container of any width up to 64.
package lfsr_pkg;

    typedef enum logic [0:0] {
        LFSR_IDLE = 1'b0,
        LFSR_RUN  = 1'b1
    } lfsr_state_e;

    // One Fibonacci shift: feedback enters at bit w-1, state moves toward bit 0.
    function automatic logic [63:0] lfsr_step(input logic [63:0] state,
                                              input logic [63:0] taps,
                                              input int          w);
        logic fb;
        fb = ^(state & taps);
        return (state >> 1) | ({63'b0, fb} << (w - 1));
    endfunction

endpackage

// File: rtl/lfsr_step_net.sv
// Purely combinational chain of STEPS LFSR shifts, unrolled at elaboration.
module lfsr_step_net
    import lfsr_pkg::*;
#(
    parameter int             W     = 13,
    parameter logic [W-1:0]   TAPS  = 13'h100D,
    parameter int             STEPS = 2
) (
    input  logic [W-1:0] state,
    output logic [W-1:0] state_next
);

    logic [63:0] chain;

    always_comb begin
        chain = 64'(state);
        for (int i = 0; i < STEPS; i++) begin
            chain = lfsr_step(chain, 64'(TAPS), W);
        end
        state_next = chain[W-1:0];
    end

endmodule

// File: rtl/lfsr_multistep.sv
// Fibonacci LFSR lane with seed load, IDLE/RUN FSM, valid/ready output and word counter.
// Optional zero-state recovery is built when LFSR_LOCKUP_RECOVER_EN is defined.
module lfsr_multistep
    import lfsr_pkg::*;
#(
    parameter int           W            = 13,
    parameter logic [W-1:0] TAPS         = 13'h100D,
    parameter int           STEPS        = 2,
    parameter logic [W-1:0] SEED_DEFAULT = 13'h0001,
    parameter int           CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [W-1:0]     i_seed,
    input  logic             i_clear,
    input  logic             i_ready,
    output logic [W-1:0]     o_lfsr,
    output logic             o_valid,
    output logic             o_lockup,
    output logic [CNT_W-1:0] o_word_cnt,
    output lfsr_state_e      o_state
);

    // Handshake: a word is accepted on a rising edge where o_valid & i_ready are
    // both high and neither i_clear nor i_load is asserted; o_lfsr is held otherwise.

    lfsr_state_e      fsm_q;
    logic [W-1:0]     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     step_out;
    logic [W-1:0]     load_val;
    logic [W-1:0]     adv_val;
    logic             accept;

    lfsr_step_net #(
        .W     (W),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_step_net (
        .state      (state_q),
        .state_next (step_out)
    );

    assign accept = (fsm_q == LFSR_RUN) && i_ready && !i_clear && !i_load;

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic load_zero;
    logic step_zero;
    logic lockup_q;

    assign load_zero = (i_seed == '0);
    assign step_zero = (step_out == '0);
    assign load_val  = load_zero ? SEED_DEFAULT : i_seed;
    assign adv_val   = step_zero ? SEED_DEFAULT : step_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= !i_clear && ((i_load && load_zero) || (accept && step_zero));
        end
    end

    assign o_lockup = lockup_q;
`else
    assign load_val = i_seed;
    assign adv_val  = step_out;
    assign o_lockup = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm_q   <= LFSR_IDLE;
            state_q <= SEED_DEFAULT;
            cnt_q   <= '0;
        end else if (i_clear) begin
            fsm_q <= LFSR_IDLE;
            cnt_q <= '0;
        end else if (i_load) begin
            fsm_q   <= LFSR_RUN;
            state_q <= load_val;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= adv_val;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign o_lfsr     = state_q;
    assign o_valid    = (fsm_q == LFSR_RUN);
    assign o_word_cnt = cnt_q;
    assign o_state    = fsm_q;

endmodule
